// File: rtl/fifo_event_spi_reader.sv
// fifo_event_spi_reader: pops one event from the keyboard event FIFO per host
// SPI frame and shifts it out on MISO, MSB first, SPI mode 0. All SPI inputs
// are oversampled in the clk domain; there is no logic clocked by SCK.
// Optional build macro FIFO_EVT_PARITY_EN appends an odd-parity bit to every frame.
module fifo_event_spi_reader #(
    parameter int unsigned EVENT_WIDTH = 8,
    parameter int unsigned RD_LATENCY  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_cs_n,
    input  logic                   spi_sck,
    output logic                   spi_miso,
    output logic                   fifo_rd,
    input  logic [EVENT_WIDTH-1:0] fifo_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic [EVENT_WIDTH-1:0] last_event
);

`ifdef FIFO_EVT_PARITY_EN
    localparam int unsigned FRAME_BITS = EVENT_WIDTH + 1;
`else
    localparam int unsigned FRAME_BITS = EVENT_WIDTH;
`endif
    localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 1);
    localparam int unsigned WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   cs_prev;
    logic                   sck_prev;
    logic                   armed;
    logic                   cs_s;
    logic                   sck_s;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_fall;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [EVENT_WIDTH-1:0] shreg_q, shreg_d;
    logic [EVENT_WIDTH-1:0] shreg_next;
    logic                   miso_d;
    logic                   fifo_rd_d;
    logic                   busy_d;
    logic                   done_d;
    logic [EVENT_WIDTH-1:0] last_d;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign sck_fall = sck_prev & ~sck_s;

    // Synchronizers, edge history and post-reset arming. The synchronizer
    // holds reset-fill values for SYNC_STAGES cycles; a frame may only start
    // after a genuine (sampled) CS-high level has been seen, so a CS that is
    // already low when rst drops does not cause a spurious request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            fill     <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
            armed    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            cs_prev  <= cs_s;
            sck_prev <= sck_s;
            armed    <= armed | (fill[SYNC_STAGES-1] & cs_s);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wait_q     <= '0;
            shreg_q    <= '0;
            spi_miso   <= 1'b0;
            fifo_rd    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            last_event <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            shreg_q    <= shreg_d;
            spi_miso   <= miso_d;
            fifo_rd    <= fifo_rd_d;
            busy       <= busy_d;
            frame_done <= done_d;
            last_event <= last_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
        shreg_d    = shreg_q;
        miso_d     = spi_miso;
        fifo_rd_d  = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;
        last_d     = last_event;
        shreg_next = shreg_q << 1;

        case (state_q)
            S_IDLE: begin
                miso_d = 1'b0;
                busy_d = 1'b0;
                if (cs_fall && armed) begin
                    state_d   = S_REQ;
                    busy_d    = 1'b1;
                    fifo_rd_d = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_W'(RD_LATENCY - 1)) begin
                    state_d = S_LOAD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_LOAD: begin
                shreg_d = fifo_data;
                last_d  = fifo_data;
                miso_d  = fifo_data[EVENT_WIDTH-1];
                cnt_d   = CNT_W'(1);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (sck_fall) begin
                    if (cnt_q < CNT_W'(EVENT_WIDTH)) begin
                        shreg_d = shreg_next;
                        miso_d  = shreg_next[EVENT_WIDTH-1];
                        cnt_d   = cnt_q + CNT_W'(1);
`ifdef FIFO_EVT_PARITY_EN
                    end else if (cnt_q == CNT_W'(EVENT_WIDTH)) begin
                        miso_d = ~(^last_event);
                        cnt_d  = cnt_q + CNT_W'(1);
`endif
                    end else begin
                        miso_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                miso_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // CS released mid-frame: drop the frame, the popped event is lost.
        if (cs_rise && (state_q == S_REQ || state_q == S_WAIT ||
                        state_q == S_LOAD || state_q == S_SHIFT)) begin
            state_d   = S_IDLE;
            miso_d    = 1'b0;
            busy_d    = 1'b0;
            fifo_rd_d = 1'b0;
            done_d    = 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_event_spi_reader.sv
// Scoreboard bench for fifo_event_spi_reader: a host task drives SPI frames and
// pushes the expected frame into a queue; a monitor pops and checks on each
// frame_done. A small FIFO model answers fifo_rd with programmable latency.
module tb_fifo_event_spi_reader;

    localparam int unsigned EW  = 8;
    localparam int unsigned RDL = 3;
    localparam int unsigned SS  = 2;
`ifdef FIFO_EVT_PARITY_EN
    localparam int unsigned FB = EW + 1;
`else
    localparam int unsigned FB = EW;
`endif
    localparam int SETUP = 20;
    localparam int PH    = 10;

    typedef struct {
        logic [EW-1:0] evt;
        logic [FB-1:0] word;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          spi_cs_n;
    logic          spi_sck;
    logic          spi_miso;
    logic          fifo_rd;
    logic [EW-1:0] fifo_data = '0;
    logic          busy;
    logic          frame_done;
    logic [EW-1:0] last_event;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] fifo_q[$];
    logic [EW-1:0] model_q[$];
    exp_t          exp_q[$];
    logic [FB-1:0] host_word = '0;
    int            rd_pulses = 0;
    int            done_pulses = 0;

    fifo_event_spi_reader #(
        .EVENT_WIDTH(EW),
        .RD_LATENCY (RDL),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_miso  (spi_miso),
        .fifo_rd   (fifo_rd),
        .fifo_data (fifo_data),
        .busy      (busy),
        .frame_done(frame_done),
        .last_event(last_event)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected serial word: the event MSB first, then odd parity when enabled.
    function automatic logic [FB-1:0] make_word(input logic [EW-1:0] evt);
        int ones;
        ones = 0;
        for (int i = 0; i < int'(EW); i++) ones += int'(evt[i]);
`ifdef FIFO_EVT_PARITY_EN
        return {evt, ((ones % 2) == 0) ? 1'b1 : 1'b0};
`else
        if (ones < 0) return '0;
        return evt;
`endif
    endfunction

    task automatic push_evt(input logic [EW-1:0] v);
        fifo_q.push_back(v);
        model_q.push_back(v);
    endtask

    // FIFO model: pops on a rising fifo_rd, data valid RDL cycles later.
    logic          rd_prev = 1'b0;
    logic [EW-1:0] pend = '0;
    int            lat_cnt = 0;
    always @(posedge clk) begin
        logic [EW-1:0] v;
        rd_prev <= fifo_rd;
        if (fifo_rd && !rd_prev) begin
            v = (fifo_q.size() != 0) ? fifo_q.pop_front() : '0;
            pend <= v;
            if (RDL == 1) begin
                fifo_data <= v;
                lat_cnt   <= 0;
            end else begin
                fifo_data <= ~v;
                lat_cnt   <= int'(RDL) - 1;
            end
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) fifo_data <= pend;
        end
    end

    // Monitor: pulse widths, pulse counts and scoreboard compare on frame_done.
    int rd_run = 0;
    int done_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (fifo_rd) begin
            if (rd_run == 0) rd_pulses++;
            rd_run++;
        end else if (rd_run > 0) begin
            chk("fifo_rd_width", 32'(rd_run), 32'd1);
            rd_run = 0;
        end
        if (frame_done) begin
            if (done_run == 0) begin
                done_pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame_done actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("last_event", 32'(last_event), 32'(e.evt));
                    chk("host_word", 32'(host_word), 32'(e.word));
                end
            end
            done_run++;
        end else if (done_run > 0) begin
            chk("frame_done_width", 32'(done_run), 32'd1);
            done_run = 0;
        end
    end

    // One host frame; abort_after >= 0 raises CS after that many SCK cycles.
    task automatic frame(input int extra, input int abort_after);
        logic [EW-1:0] evt;
        exp_t          e;
        int            rd0, dn0, n;
        evt = (model_q.size() != 0) ? model_q.pop_front() : '0;
        if (abort_after < 0) begin
            e.evt  = evt;
            e.word = make_word(evt);
            exp_q.push_back(e);
        end
        rd0 = rd_pulses;
        dn0 = done_pulses;
        spi_cs_n = 1'b0;
        cyc(SETUP);
        host_word = '0;
        n = (abort_after >= 0) ? abort_after : int'(FB) + extra;
        for (int i = 0; i < n; i++) begin
            if (i < int'(FB)) host_word = {host_word[FB-2:0], spi_miso};
            else chk("miso_after_frame", 32'(spi_miso), 32'd0);
            spi_sck = 1'b1;
            cyc(PH);
            spi_sck = 1'b0;
            cyc(PH);
        end
        if (abort_after < 0) chk("busy_in_frame", 32'(busy), 32'd1);
        spi_cs_n = 1'b1;
        cyc(int'(SS) + 1);
        chk("busy_after_cs_rise", 32'(busy), 32'd0);
        chk("miso_idle", 32'(spi_miso), 32'd0);
        cyc(PH);
        chk("fifo_rd_count", 32'(rd_pulses - rd0), 32'd1);
        chk("frame_done_count", 32'(done_pulses - dn0), (abort_after < 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, waited;
        rst      = 1'b1;
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        cyc(3);
        chk("rst_miso", 32'(spi_miso), 32'd0);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_last_event", 32'(last_event), 32'd0);
        rst = 1'b0;
        cyc(10);

        push_evt(8'hA5);
        frame(0, -1);
        frame(0, -1);
        push_evt(8'h11);
        push_evt(8'h22);
        push_evt(8'h33);
        repeat (3) frame(0, -1);

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) != 0) push_evt(EW'($urandom));
            frame(0, -1);
        end

        push_evt(8'hF0);
        push_evt(8'h5C);
        frame(0, 4);
        frame(0, -1);

        // Reset while waiting on FIFO read latency.
        push_evt(8'h77);
        void'(model_q.pop_front());
        rd0 = rd_pulses;
        spi_cs_n = 1'b0;
        waited = 0;
        while (rd_pulses == rd0 && waited < 50) begin
            cyc(1);
            waited++;
        end
        chk("rd_before_rst_seen", 32'(rd_pulses - rd0), 32'd1);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("midrst_miso", 32'(spi_miso), 32'd0);
        chk("midrst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame_done", 32'(frame_done), 32'd0);
        chk("midrst_last_event", 32'(last_event), 32'd0);
        rst = 1'b0;
        rd0 = rd_pulses;
        cyc(40);
        chk("no_rd_after_rst", 32'(rd_pulses - rd0), 32'd0);
        chk("idle_after_rst", 32'(busy), 32'd0);
        spi_cs_n = 1'b1;
        cyc(10);

        push_evt(8'h3C);
        frame(12, -1);

`ifdef FIFO_EVT_PARITY_EN
        push_evt(8'h03);
        push_evt(8'h07);
        frame(0, -1);
        frame(0, -1);
`endif

        cyc(20);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
